// File: rtl/deser_32b_to_100b.sv
// deser_32b_to_100b: assembles groups of IN_NBITS-wide beats into one
// OUT_NBITS-wide word and presents it on a registered val/rdy output.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   in_val   upstream beat valid
//   in_rdy   block can accept a beat this cycle (combinational from out_rdy)
//   in_      beat data
//   out_val  assembled word valid (registered)
//   out_rdy  downstream accepts the word this cycle
//   out      assembled word (registered)
module deser_32b_to_100b #(
  parameter int unsigned IN_NBITS  = 32,
  parameter int unsigned OUT_NBITS = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [IN_NBITS-1:0]  in_,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [OUT_NBITS-1:0] out
);

  localparam int unsigned NBEATS  = (OUT_NBITS + IN_NBITS - 1) / IN_NBITS;
  localparam int unsigned CNT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned LAST_W  = OUT_NBITS - (NBEATS - 1) * IN_NBITS;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_NBITS-1:0]   wreg_q, wreg_d;
  logic                   in_xfer;
  logic                   out_xfer;

  // Ready whenever empty, or when the held word leaves on this same edge.
  assign in_rdy   = reset & ((state_q != S_FULL) | out_rdy);
  assign in_xfer  = in_val & in_rdy;
  assign out_xfer = (state_q == S_FULL) & out_rdy;

  assign out_val  = (state_q == S_FULL);
  assign out      = wreg_q;

  // State register, beat counter and word register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      wreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wreg_q  <= wreg_d;
    end
  end

  // Next-state: while FULL the counter sits at 0, so cnt_q is also the
  // correct beat slot for a beat accepted alongside an output transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wreg_d  = wreg_q;

    if (in_xfer) begin
      for (int unsigned k = 0; k < NBEATS - 1; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          wreg_d[k*IN_NBITS +: IN_NBITS] = in_;
        end
      end
      // Final beat only supplies the remaining top bits; the rest is dropped.
      if (cnt_q == LAST_BEAT) begin
        wreg_d[OUT_NBITS-1 -: LAST_W] = in_[LAST_W-1:0];
      end
    end

    unique case (state_q)
      S_FILL: begin
        if (in_xfer) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_FULL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FULL: begin
        if (out_xfer) begin
          state_d = S_FILL;
          if (in_xfer) begin
            cnt_d = CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_deser_32b_to_100b.sv
// Directed testbench for deser_32b_to_100b. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_deser_32b_to_100b;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_val = 1'b0;
  logic         in_rdy;
  logic [31:0]  in_data = '0;
  logic         out_val;
  logic         out_rdy = 1'b0;
  logic [99:0]  out_word;

  int errors = 0;
  int checks = 0;

  deser_32b_to_100b dut (
    .clk     (clk),
    .reset   (rst_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_     (in_data),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out     (out_word)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_val !== 1'b0) begin
      errors++; $display("FAIL reset_out_val: got %b expected 0", out_val);
    end
    checks++;
    if (out_word !== 100'h0) begin
      errors++; $display("FAIL reset_out: got %h expected 0", out_word);
    end
    checks++;
    if (in_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_in_rdy: got %b expected 0", in_rdy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++; $display("FAIL release_in_rdy: got %b expected 1", in_rdy);
    end
  endtask

  task automatic test_basic();
    logic [31:0] beats [4];
    beats[0] = 32'h89abcdef; beats[1] = 32'h01234567;
    beats[2] = 32'hdeadbeef; beats[3] = 32'h0000000f;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_val !== 1'b0) begin
          errors++; $display("FAIL basic_early_val[%0d]: got %b expected 0", i, out_val);
        end
      end
      in_val = 1'b1; in_data = beats[i];
    end
    @(negedge clk);
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1) begin
      errors++; $display("FAIL basic_out_val: got %b expected 1", out_val);
    end
    checks++;
    if (out_word !== 100'hf_deadbeef_01234567_89abcdef) begin
      errors++; $display("FAIL basic_out: got %h expected %h", out_word, 100'hf_deadbeef_01234567_89abcdef);
    end
    @(negedge clk);
    checks++;
    if (out_val !== 1'b0) begin
      errors++; $display("FAIL basic_val_drop: got %b expected 0", out_val);
    end
  endtask

  task automatic test_truncation();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_val = 1'b1; in_data = (i == 3) ? 32'hfffffff5 : 32'h0;
    end
    @(negedge clk);
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1) begin
      errors++; $display("FAIL trunc_out_val: got %b expected 1", out_val);
    end
    checks++;
    if (out_word !== 100'h5_00000000_00000000_00000000) begin
      errors++; $display("FAIL trunc_out: got %h expected %h", out_word, 100'h5_00000000_00000000_00000000);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] beats [4];
    logic [99:0] w0;
    logic [99:0] w1;
    beats[0] = 32'haaaaaaaa; beats[1] = 32'hbbbbbbbb;
    beats[2] = 32'hcccccccc; beats[3] = 32'h0000000d;
    w0 = 100'hd_cccccccc_bbbbbbbb_aaaaaaaa;
    w1 = 100'h4_33333333_22222222_11111111;
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_val = 1'b1; in_data = beats[i];
    end
    @(negedge clk);
    in_val = 1'b1; in_data = 32'h11111111;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (in_rdy !== 1'b0) begin
        errors++; $display("FAIL bp_in_rdy[%0d]: got %b expected 0", c, in_rdy);
      end
      checks++;
      if (out_val !== 1'b1) begin
        errors++; $display("FAIL bp_out_val[%0d]: got %b expected 1", c, out_val);
      end
      checks++;
      if (out_word !== w0) begin
        errors++; $display("FAIL bp_out_hold[%0d]: got %h expected %h", c, out_word, w0);
      end
      if (c < 4) @(negedge clk);
    end
    out_rdy = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++; $display("FAIL bp_release_in_rdy: got %b expected 1", in_rdy);
    end
    @(negedge clk);
    checks++;
    if (out_val !== 1'b0) begin
      errors++; $display("FAIL bp_drained: got %b expected 0", out_val);
    end
    in_data = 32'h22222222;
    @(negedge clk);
    in_data = 32'h33333333;
    @(negedge clk);
    checks++;
    if (out_val !== 1'b0) begin
      errors++; $display("FAIL bp_early_val: got %b expected 0", out_val);
    end
    in_data = 32'h00000004;
    @(negedge clk);
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1) begin
      errors++; $display("FAIL bp_next_val: got %b expected 1", out_val);
    end
    checks++;
    if (out_word !== w1) begin
      errors++; $display("FAIL bp_next_word: got %h expected %h", out_word, w1);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_rdy = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_val !== ((i == 4) || (i == 8))) begin
        errors++; $display("FAIL b2b_out_val[%0d]: got %b expected %b", i, out_val, (i == 4) || (i == 8));
      end
      if (i == 4) begin
        checks++;
        if (out_word !== 100'h3_00000002_00000001_00000000) begin
          errors++; $display("FAIL b2b_word0: got %h expected %h", out_word, 100'h3_00000002_00000001_00000000);
        end
      end
      if (i == 8) begin
        checks++;
        if (out_word !== 100'h7_00000006_00000005_00000004) begin
          errors++; $display("FAIL b2b_word1: got %h expected %h", out_word, 100'h7_00000006_00000005_00000004);
        end
      end
      checks++;
      if (in_rdy !== 1'b1) begin
        errors++; $display("FAIL b2b_in_rdy[%0d]: got %b expected 1", i, in_rdy);
      end
      in_val  = (i < 8);
      in_data = 32'(i);
    end
    @(negedge clk);
  endtask

  task automatic test_gapped();
    logic [31:0] beats [4];
    beats[0] = 32'h01010101; beats[1] = 32'h02020202;
    beats[2] = 32'h03030303; beats[3] = 32'h0000000e;
    out_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_val !== 1'b0) begin
          errors++; $display("FAIL gap_early_val[%0d]: got %b expected 0", i, out_val);
        end
      end
      if (i % 2 == 0) begin
        in_val = 1'b1; in_data = beats[i/2];
      end else begin
        in_val = 1'b0; in_data = 32'hdeaddead;
      end
    end
    @(negedge clk);
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1) begin
      errors++; $display("FAIL gap_out_val: got %b expected 1", out_val);
    end
    checks++;
    if (out_word !== 100'he_03030303_02020202_01010101) begin
      errors++; $display("FAIL gap_word: got %h expected %h", out_word, 100'he_03030303_02020202_01010101);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] beats [4];
    beats[0] = 32'h00000010; beats[1] = 32'h00000020;
    beats[2] = 32'h00000030; beats[3] = 32'h00000004;
    out_rdy = 1'b1;
    @(negedge clk);
    in_val = 1'b1; in_data = 32'hffffffff;
    @(negedge clk);
    in_data = 32'heeeeeeee;
    @(negedge clk);
    in_val = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out_val: got %b expected 0", out_val);
    end
    checks++;
    if (out_word !== 100'h0) begin
      errors++; $display("FAIL rst_mid_out: got %h expected 0", out_word);
    end
    checks++;
    if (in_rdy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_in_rdy: got %b expected 0", in_rdy);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_val !== 1'b0) begin
          errors++; $display("FAIL rst_fresh_early_val[%0d]: got %b expected 0", i, out_val);
        end
      end
      in_val = 1'b1; in_data = beats[i];
    end
    @(negedge clk);
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1) begin
      errors++; $display("FAIL rst_fresh_val: got %b expected 1", out_val);
    end
    checks++;
    if (out_word !== 100'h4_00000030_00000020_00000010) begin
      errors++; $display("FAIL rst_fresh_word: got %h expected %h", out_word, 100'h4_00000030_00000020_00000010);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_backpressure();
    test_back_to_back();
    test_gapped();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
